// File: rtl/instruction_queue_pkg.sv
// Shared CPU front-end types: the {PC, instruction} pair carried from fetch to decode.
package instruction_queue_pkg;

  localparam int IQ_DEPTH_DEFAULT = 8;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } iq_entry_t;

endpackage

// File: rtl/instruction_queue.sv
// Circular FIFO of fetched {PC, instruction} pairs; the oldest entry is presented to decode.
// A flush from fetch empties the queue on every cycle it is held.
module instruction_queue
  import instruction_queue_pkg::*;
#(
  parameter int DEPTH   = IQ_DEPTH_DEFAULT,
  parameter int RESERVE = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_iq_fetch,
  input  logic [31:0]                pc_in,
  input  logic [31:0]                instr_in,
  input  logic                       flush_iq_fetch,
  output logic                       iq_really_full,
  output logic                       iq_valid,
  output logic [31:0]                iq_pc,
  output logic [31:0]                iq_instr,
  input  logic                       iq_deq,
  output logic [$clog2(DEPTH):0]     iq_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_AT  = CNT_W'(DEPTH - RESERVE);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);

  iq_entry_t        mem [DEPTH];
  iq_entry_t        head_entry;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] ptr_diff;
  logic [CNT_W-1:0] count;
  logic             enq;
  logic             deq;

  // Full depends on count alone so fetch can use it without a loop through load/deq.
  assign iq_really_full = (count >= FULL_AT);
  assign iq_valid       = (count != '0);
  assign iq_count       = count;
  assign enq            = load_iq_fetch & ~iq_really_full;
  assign deq            = iq_deq & iq_valid;
  assign ptr_diff       = tail - head;

  always_ff @(posedge clk) begin
    if (rst || flush_iq_fetch) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) tail <= tail + PTR_W'(1);
      if (deq) head <= head + PTR_W'(1);
      unique case ({enq, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; a flushed or reset cycle must not write a stale slot.
  always_ff @(posedge clk) begin
    if (enq && !flush_iq_fetch && !rst) begin
      mem[tail] <= '{pc: pc_in, instr: instr_in};
    end
  end

  always_comb begin
    head_entry = mem[head];
    iq_pc      = '0;
    iq_instr   = '0;
    if (iq_valid) begin
      iq_pc    = head_entry.pc;
      iq_instr = head_entry.instr;
    end
  end

  a_count_bound: assert property (@(posedge clk) disable iff (rst) count <= DEPTH_C);
  a_no_enq_full: assert property (@(posedge clk) disable iff (rst) !(enq && count == DEPTH_C));
  a_ptr_count:   assert property (@(posedge clk) disable iff (rst) ptr_diff == count[PTR_W-1:0]);

endmodule

// File: tb/tb_instruction_queue.sv
// Bench for instruction_queue: two instances (RESERVE 0 and 2) checked every cycle
// against a queue-based model, plus directed literal expectations.
module tb_instruction_queue;
  import instruction_queue_pkg::*;

  localparam int DEPTH     = 8;
  localparam int RESERVE_B = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        load_a = 1'b0, flush_a = 1'b0, deq_a = 1'b0;
  logic [31:0] pc_a = '0, instr_a = '0;
  logic        full_a, valid_a;
  logic [31:0] iq_pc_a, iq_instr_a;
  logic [3:0]  count_a;

  logic        load_b = 1'b0, flush_b = 1'b0, deq_b = 1'b0;
  logic [31:0] pc_b = '0, instr_b = '0;
  logic        full_b, valid_b;
  logic [31:0] iq_pc_b, iq_instr_b;
  logic [3:0]  count_b;

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;
  logic [63:0] model_a[$];
  logic [63:0] model_b[$];

  instruction_queue #(.DEPTH(DEPTH), .RESERVE(0)) dut_a (
    .clk(clk), .rst(rst), .load_iq_fetch(load_a), .pc_in(pc_a), .instr_in(instr_a),
    .flush_iq_fetch(flush_a), .iq_really_full(full_a), .iq_valid(valid_a),
    .iq_pc(iq_pc_a), .iq_instr(iq_instr_a), .iq_deq(deq_a), .iq_count(count_a)
  );

  instruction_queue #(.DEPTH(DEPTH), .RESERVE(RESERVE_B)) dut_b (
    .clk(clk), .rst(rst), .load_iq_fetch(load_b), .pc_in(pc_b), .instr_in(instr_b),
    .flush_iq_fetch(flush_b), .iq_really_full(full_b), .iq_valid(valid_b),
    .iq_pc(iq_pc_b), .iq_instr(iq_instr_b), .iq_deq(deq_b), .iq_count(count_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a queue that accepts while below its full threshold and empties on rst/flush.
  always @(posedge clk) begin : model_update
    bit full_now_a;
    bit full_now_b;
    full_now_a = model_a.size() >= DEPTH;
    full_now_b = model_b.size() >= DEPTH - RESERVE_B;
    if (rst || flush_a) model_a.delete();
    else begin
      if (deq_a && model_a.size() != 0) void'(model_a.pop_front());
      if (load_a && !full_now_a) model_a.push_back({pc_a, instr_a});
    end
    if (rst || flush_b) model_b.delete();
    else begin
      if (deq_b && model_b.size() != 0) void'(model_b.pop_front());
      if (load_b && !full_now_b) model_b.push_back({pc_b, instr_b});
    end
    if (rst) checking = 1'b1;
  end

  task automatic check_output();
    logic [63:0] ea;
    logic [63:0] eb;
    ea = (model_a.size() > 0) ? model_a[0] : 64'h0;
    eb = (model_b.size() > 0) ? model_b[0] : 64'h0;
    check("a_valid", 32'(valid_a), 32'(model_a.size() > 0));
    check("a_count", 32'(count_a), 32'(model_a.size()));
    check("a_full", 32'(full_a), 32'(model_a.size() >= DEPTH));
    check("a_pc", iq_pc_a, ea[63:32]);
    check("a_instr", iq_instr_a, ea[31:0]);
    check("b_valid", 32'(valid_b), 32'(model_b.size() > 0));
    check("b_count", 32'(count_b), 32'(model_b.size()));
    check("b_full", 32'(full_b), 32'(model_b.size() >= DEPTH - RESERVE_B));
    check("b_pc", iq_pc_b, eb[63:32]);
    check("b_instr", iq_instr_b, eb[31:0]);
  endtask

  always @(negedge clk) begin
    if (checking) check_output();
  end

  task automatic set_a(input logic load, input logic [31:0] pc, input logic flush, input logic deq);
    load_a  = load;
    pc_a    = pc;
    instr_a = pc ^ 32'h1357_9BDF;
    flush_a = flush;
    deq_a   = deq;
  endtask

  task automatic set_b(input logic load, input logic [31:0] pc, input logic deq);
    load_b  = load;
    pc_b    = pc;
    instr_b = pc ^ 32'h2468_ACE0;
    deq_b   = deq;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_stimulus(input logic load, input logic [31:0] pc, input logic flush, input logic deq);
    set_a(load, pc, flush, deq);
    step();
  endtask

  initial begin
    // Reset
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0);
    step();
    step();
    rst = 1'b0;
    check("rst_count", 32'(count_a), 32'd0);
    check("rst_valid", 32'(valid_a), 32'd0);
    check("rst_pc", iq_pc_a, 32'h0);
    check("rst_full", 32'(full_a), 32'd0);

    // Three loads; no bypass into an empty queue
    set_a(1, 32'h60, 0, 0);
    #1;
    check("s1_no_bypass", 32'(valid_a), 32'd0);
    step();
    check("s1_valid_rise", 32'(valid_a), 32'd1);
    apply_stimulus(1, 32'h64, 0, 0);
    apply_stimulus(1, 32'h68, 0, 0);
    set_a(0, 0, 0, 0);
    check("s1_count", 32'(count_a), 32'd3);
    check("s1_head_pc", iq_pc_a, 32'h60);
    check("s1_head_instr", iq_instr_a, 32'h1357_9BBF);

    // Fill to 8, drop a 9th, drain in order
    for (int i = 3; i < 8; i++) apply_stimulus(1, 32'h60 + 32'(4 * i), 0, 0);
    check("s2_count_full", 32'(count_a), 32'd8);
    check("s2_full", 32'(full_a), 32'd1);
    apply_stimulus(1, 32'h80, 0, 0);
    check("s2_drop", 32'(count_a), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check("s2_order", iq_pc_a, 32'h60 + 32'(4 * i));
      apply_stimulus(0, 0, 0, 1);
    end
    check("s2_empty", 32'(count_a), 32'd0);

    // Full queue with load+deq: load is blocked by full; at count 7 both advance
    for (int i = 0; i < 8; i++) apply_stimulus(1, 32'h60 + 32'(4 * i), 0, 0);
    apply_stimulus(1, 32'h88, 0, 1);
    check("s3_full_ld_deq", 32'(count_a), 32'd7);
    apply_stimulus(1, 32'h90, 0, 1);
    check("s3_ld_deq_count", 32'(count_a), 32'd7);
    check("s3_head", iq_pc_a, 32'h68);
    for (int i = 0; i < 7; i++) begin
      check("s3_order", iq_pc_a, (i < 6) ? 32'h68 + 32'(4 * i) : 32'h90);
      apply_stimulus(0, 0, 0, 1);
    end

    // Flush at occupancy 5 with same-cycle load and deq
    for (int i = 0; i < 5; i++) apply_stimulus(1, 32'hA0 + 32'(4 * i), 0, 0);
    check("s4_count5", 32'(count_a), 32'd5);
    apply_stimulus(1, 32'hC0, 1, 1);
    check("s4_count", 32'(count_a), 32'd0);
    check("s4_valid", 32'(valid_a), 32'd0);
    check("s4_pc", iq_pc_a, 32'h0);
    apply_stimulus(0, 0, 0, 0);
    check("s4_stays_empty", 32'(count_a), 32'd0);

    // Held flush with loads every cycle
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1, 32'hD0 + 32'(4 * i), 1, 0);
      check("s5_flush_count", 32'(count_a), 32'd0);
      check("s5_flush_valid", 32'(valid_a), 32'd0);
    end
    apply_stimulus(1, 32'h80, 0, 0);
    check("s5_head_pc", iq_pc_a, 32'h80);
    check("s5_count", 32'(count_a), 32'd1);
    apply_stimulus(0, 0, 0, 1);
    set_a(0, 0, 0, 0);

    // RESERVE=2 instance: full at 6, clears at 5, then reset at count 4
    for (int i = 0; i < 6; i++) begin
      set_b(1, 32'h100 + 32'(4 * i), 0);
      step();
      if (i == 4) check("s6_not_full_at5", 32'(full_b), 32'd0);
    end
    check("s6_full_at6", 32'(full_b), 32'd1);
    check("s6_count6", 32'(count_b), 32'd6);
    set_b(1, 32'h200, 0);
    step();
    check("s6_drop", 32'(count_b), 32'd6);
    set_b(0, 0, 1);
    step();
    check("s6_count5", 32'(count_b), 32'd5);
    check("s6_full_clear", 32'(full_b), 32'd0);
    step();
    check("s6_count4", 32'(count_b), 32'd4);
    check("s6_head4", iq_pc_b, 32'h108);
    rst = 1'b1;
    set_b(1, 32'h300, 1);
    step();
    check("s6_rst_count", 32'(count_b), 32'd0);
    check("s6_rst_valid", 32'(valid_b), 32'd0);
    check("s6_rst_pc", iq_pc_b, 32'h0);
    check("s6_rst_instr", iq_instr_b, 32'h0);
    check("s6_rst_full", 32'(full_b), 32'd0);
    rst = 1'b0;
    set_b(0, 0, 0);
    step();
    check("s6_after_rst", 32'(count_b), 32'd0);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
